prach_tdm_stim_gen: RTL
=======================

Name: prach_tdm_stim_gen

Overview:
- Synthesizable, parametrised TDM stimulus source for the PRACH front end.
- Drives the `avst_sink_*` interface of `prach_top` in the `clk_jesd` domain: one beat per channel slot, carrying all antennas in parallel.
- Modes: counting pattern, RAM-held test vector on one selected antenna/CC lane, or zeros.
- Supports bounded bursts, graceful stop and an aligned sync pulse, for on-board self-test and bench reuse.

Parameters:
- NUM_ANT, 8, antennas packed per beat.
- NUM_CHN, 4, TDM channel slots per sample period (slots 0..NUM_CHN-1).
- IQ_W, 16, bits per I or Q component; must be ≥ 16.
- TV_DEPTH, 30720, test-vector RAM depth in IQ samples.
- TV_AW, $clog2(TV_DEPTH), RAM address width.

Ports:
- clk_jesd  in  1  stream clock.
- rst_jesd_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle graceful-stop request.
- mode  in  2  0=count, 1=test vector, 2=zero, 3=PRBS (optional feature).
- burst_len  in  16  samples per burst; 0 = continuous.
- sel_ant  in  3  antenna lane receiving the test vector.
- sel_chn  in  2  slot receiving the test vector.
- tv_wr_en  in  1  RAM write strobe.
- tv_wr_addr  in  TV_AW  RAM write address.
- tv_wr_data  in  2*IQ_W  {Q,I} sample.
- avst_sink_data  out  NUM_ANT*2*IQ_W  packed beat.
- avst_sink_valid  out  1  beat valid.
- avst_sink_channel  out  8  slot index.
- sync_out  out  1  pulse on first beat of a burst.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0. RAM contents are not reset.
- Configuration capture: mode, burst_len, sel_ant and sel_chn are captured on an accepted start and held for the whole burst.

FSM states:
- IDLE: a start request moves the FSM to RUN. A stop request in IDLE is ignored, so start wins if both arrive together.
- RUN:
  - Slot counter `c` steps 0..NUM_CHN-1 every cycle, so there are no gaps.
  - Sample counter `i` increments when `c` wraps.
  - Leave RUN when `c` wraps with either of:
    - `i` = burst_len-1 (only when burst_len ≠ 0);
    - a pending stop.
  - A stop request is latched and honoured at the next slot wrap; the current sample period always completes.
  - Start requests received while in RUN are ignored.
- DRAIN: the FSM spends 2 cycles here while the pipeline flushes, then returns to IDLE.

Pipeline and outputs:
- Output latency: a start accepted on edge N gives the first valid beat on edge N+2, in every mode. This covers the RAM read (1 cycle) plus the output register.
- `done`: asserted together with the cycle after the last valid beat. `busy` deasserts in that same cycle.
- `sync_out`: high together with the beat (i=0, c=0) of each burst.
- `avst_sink_channel`: equals `c`, zero-extended. It is 0 whenever valid is low.
- `avst_sink_data`: 0 whenever valid is low.

Lane packing:
- Antenna `a` occupies `[NUM_ANT*2*IQ_W-1-2*IQ_W*a -: 2*IQ_W]`, laid out as {Q, I}.

Mode 0 (count), per lane a, in the 16 LSBs of each component; upper bits are 0:
- I = {a[3:0], c[3:0], 4'h0, i[3:0]}
- Q = {a[3:0], c[3:0], 4'hF, i[3:0]}

Mode 1 (test vector):
- Lane sel_ant in slot sel_chn carries RAM[i mod TV_DEPTH]. The address wraps to 0 after TV_DEPTH-1.
- All other lanes and slots are 0.

Mode 2 (zero): valid beats with all-zero data.

RAM:
- Simple dual-port.
- Writes are allowed at any time.
- A read and write to the same address in the same cycle returns the old data.

Sample counter:
- 16 bits. In continuous mode it wraps 65535→0; sync_out is not re-pulsed on wrap.

Reset mid-burst: outputs drop to 0 immediately (async). No done pulse is generated.

Optional Feature:
- Macro: `PRACH_STIM_PRBS_EN`.
- With the macro defined, mode 3 generates PRBS-15 data (x^15+x^14+1):
  - One LFSR per lane, seeded with 15'h7FFF ^ a on start.
  - The LFSR advances once per valid beat.
  - I = sign-extended LFSR[14:0]; Q = bitwise-inverse of I.
- Without the macro, mode 3 behaves exactly like mode 2, and no LFSR logic is synthesised.

Test Plan:
1. Counting burst: mode=0, burst_len=3, start → 12 valid beats from N+2 with channel sequence 0,1,2,3 ×3. Ant 5 slot 2, i=1 gives I=16'h5201, Q=16'h52F1. sync_out only on beat 0. done 1 cycle after beat 11. busy low afterwards.
2. Test vector with wrap: TV_DEPTH=4 override, RAM={0x11,0x22,0x33,0x44}, mode=1, sel_ant=0, sel_chn=0, burst_len=6 → slot-0 lane-0 data 11,22,33,44,11,22. All other lanes and slots are 0.
3. Graceful stop: continuous mode, stop asserted at c=1 of i=7 → beats continue through c=3 of i=7, then valid drops. Total 32 beats, then done.
4. Collisions: start+stop in the same IDLE cycle → burst starts. Start during RUN → ignored, no restart of sync_out. Same-address RAM read/write → old data on output.
5. Async reset asserted mid-burst at beat 5 → valid, data, channel, busy all 0 immediately. No done pulse. A new start after release behaves as in scenario 1.
6. With `PRACH_STIM_PRBS_EN` defined, mode=3 → lane 0 first I = 16'h7FFF-derived value matching a reference LFSR for 100 beats. With the macro undefined, mode=3 → all-zero valid beats.

Source files
------------

// File: rtl/prach_tdm_stim_gen.sv
// prach_tdm_stim_gen: TDM stimulus source (count / RAM test vector / zero) for the PRACH avst sink.
// Defining PRACH_STIM_PRBS_EN turns mode 3 into per-lane PRBS-15; otherwise mode 3 emits zeros.
module prach_tdm_stim_gen #(
  parameter int NUM_ANT  = 8,
  parameter int NUM_CHN  = 4,
  parameter int IQ_W     = 16,
  parameter int TV_DEPTH = 30720,
  parameter int TV_AW    = $clog2(TV_DEPTH)
) (
  input  logic                        clk_jesd,
  input  logic                        rst_jesd_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 burst_len,
  input  logic [2:0]                  sel_ant,
  input  logic [1:0]                  sel_chn,
  input  logic                        tv_wr_en,
  input  logic [TV_AW-1:0]            tv_wr_addr,
  input  logic [2*IQ_W-1:0]           tv_wr_data,
  output logic [NUM_ANT*2*IQ_W-1:0]   avst_sink_data,
  output logic                        avst_sink_valid,
  output logic [7:0]                  avst_sink_channel,
  output logic                        sync_out,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = NUM_CHN > 1 ? $clog2(NUM_CHN) : 1;
  localparam int LW = 2*IQ_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] c, c1;
  logic [15:0] i, bl_q;
  logic [3:0] i1;
  logic [TV_AW-1:0] ra;
  logic [1:0] m_q, sc_q;
  logic [2:0] sa_q;
  logic first, stop_pend, dcnt, v1, s1, go, run, wrap, last;
  logic [LW-1:0] mem [TV_DEPTH];
  logic [LW-1:0] rd_q;
  logic [0:NUM_ANT-1][LW-1:0] lane_d;

  assign wrap = c == CW'(NUM_CHN-1);
  assign last = bl_q != 16'd0 && i == bl_q - 16'd1;

  always_ff @(posedge clk_jesd or negedge rst_jesd_n)
    if (!rst_jesd_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (wrap && (last || stop || stop_pend)) state_nx = DRAIN;
      DRAIN:   if (dcnt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    go   = state == IDLE && start;
    run  = state == RUN;
    busy = state != IDLE;
  end

  always_ff @(posedge clk_jesd or negedge rst_jesd_n)
    if (!rst_jesd_n) begin
      c <= '0; i <= '0; ra <= '0; first <= 1'b0; stop_pend <= 1'b0; dcnt <= 1'b0;
      m_q <= '0; bl_q <= '0; sa_q <= '0; sc_q <= '0;
    end else begin
      dcnt <= state == DRAIN && !dcnt;
      stop_pend <= run && (stop_pend || stop);
      if (go) begin
        c <= '0; i <= '0; ra <= '0; first <= 1'b1;
        m_q <= mode; bl_q <= burst_len; sa_q <= sel_ant; sc_q <= sel_chn;
      end else if (run) begin
        c <= wrap ? '0 : c + CW'(1);
        first <= 1'b0;
        if (wrap) begin
          i <= i + 16'd1;
          ra <= ra == TV_AW'(TV_DEPTH-1) ? '0 : ra + TV_AW'(1);
        end
      end
    end

  // Read-before-write: a same-address collision returns the old word
  always_ff @(posedge clk_jesd) begin
    if (tv_wr_en) mem[tv_wr_addr] <= tv_wr_data;
    rd_q <= mem[ra];
  end

  for (genvar a = 0; a < NUM_ANT; a++) begin : g_lane
    logic [IQ_W-1:0] ci, cq;
    logic [LW-1:0] pl;
    assign ci = IQ_W'({4'(a), 4'(c1), 4'h0, i1});
    assign cq = IQ_W'({4'(a), 4'(c1), 4'hF, i1});
`ifdef PRACH_STIM_PRBS_EN
    logic [14:0] lfsr;
    logic [IQ_W-1:0] pi;
    always_ff @(posedge clk_jesd or negedge rst_jesd_n)
      if (!rst_jesd_n) lfsr <= '0;
      else if (go) lfsr <= 15'h7FFF ^ 15'(a);
      else if (v1) lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    assign pi = IQ_W'($signed(lfsr));
    assign pl = {~pi, pi};
`else
    assign pl = '0;
`endif
    assign lane_d[a] = !v1 ? '0 :
                       m_q == 2'd0 ? {cq, ci} :
                       m_q == 2'd1 ? ((3'(a) == sa_q && c1 == CW'(sc_q)) ? rd_q : '0) :
                       m_q == 2'd3 ? pl : '0;
  end

  always_ff @(posedge clk_jesd or negedge rst_jesd_n)
    if (!rst_jesd_n) begin
      v1 <= 1'b0; s1 <= 1'b0; c1 <= '0; i1 <= '0;
      avst_sink_valid <= 1'b0; avst_sink_channel <= '0; avst_sink_data <= '0;
      sync_out <= 1'b0; done <= 1'b0;
    end else begin
      v1 <= run;
      s1 <= run && first;
      c1 <= c;
      i1 <= i[3:0];
      avst_sink_valid <= v1;
      avst_sink_channel <= v1 ? 8'(c1) : 8'h0;
      avst_sink_data <= lane_d;
      sync_out <= s1;
      done <= state == DRAIN && dcnt;
    end
endmodule
